// File: rtl/pll_rst_pkg.sv
// pll_rst_pkg: shared state encoding for the PLL lock reset generator.
package pll_rst_pkg;
    localparam int ST_W = 2;
    typedef enum logic [ST_W-1:0] {
        ST_WAIT_LOCK = 2'b00,
        ST_QUALIFY   = 2'b01,
        ST_RUN       = 2'b10
    } st_e;
endpackage

// File: rtl/pll_lock_rst_gen_sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous input.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {q, meta} <= 2'b00;
        else        {q, meta} <= {meta, d};
endmodule

// File: rtl/pll_lock_rst_gen.sv
// pll_lock_rst_gen: qualifies PLL lock and releases a clk_div reset, counts losses, drives heartbeat.
module pll_lock_rst_gen
    import pll_rst_pkg::*;
#(
    parameter int STABLE_CYCLES = 16,
    parameter int LOSS_CNT_W    = 8,
    parameter int HB_DIV        = 12_500_000
) (
    input  logic                  clk_div,
    input  logic                  sys_rst_n,
    input  logic                  locked,
    output logic                  rst_out_n,
    output logic                  ready,
    output logic [LOSS_CNT_W-1:0] loss_cnt,
    output logic                  heartbeat,
    output logic [ST_W-1:0]       state
);
    localparam int QW = $clog2(STABLE_CYCLES);
    localparam int HW = $clog2(HB_DIV);
    localparam logic [QW-1:0] Q_LAST = QW'(STABLE_CYCLES - 1);
    localparam logic [HW-1:0] H_LAST = HW'(HB_DIV - 1);
    logic          locked_s;
    logic [QW-1:0] qcnt;
    logic [HW-1:0] hcnt;
    st_e           st;
    assign state = st;
    sync_2ff u_sync_locked (.clk(clk_div), .rst_n(sys_rst_n), .d(locked), .q(locked_s));
    always_ff @(posedge clk_div or negedge sys_rst_n)
        if (!sys_rst_n) begin
            st        <= ST_WAIT_LOCK;
            rst_out_n <= 1'b0;
            ready     <= 1'b0;
            heartbeat <= 1'b0;
            loss_cnt  <= '0;
            qcnt      <= '0;
            hcnt      <= '0;
        end else begin
            case (st)
                ST_WAIT_LOCK:
                    if (locked_s) begin
                        st   <= ST_QUALIFY;
                        qcnt <= '0;
                    end
                ST_QUALIFY:
                    if (!locked_s) begin
                        st   <= ST_WAIT_LOCK;
                        qcnt <= '0;
                    end else if (qcnt == Q_LAST) begin
                        st        <= ST_RUN;
                        qcnt      <= '0;
                        rst_out_n <= 1'b1;
                        ready     <= 1'b1;
                    end else qcnt <= qcnt + 1'b1;
                ST_RUN:
                    if (!locked_s) begin
                        st        <= ST_WAIT_LOCK;
                        rst_out_n <= 1'b0;
                        ready     <= 1'b0;
                        hcnt      <= '0;
                        heartbeat <= 1'b0;
                        if (loss_cnt != '1) loss_cnt <= loss_cnt + 1'b1;
                    end else if (hcnt == H_LAST) begin
                        hcnt      <= '0;
                        heartbeat <= ~heartbeat;
                    end else hcnt <= hcnt + 1'b1;
                default: begin
                    // the unused encoding recovers like a fresh start, keeping loss history
                    st        <= ST_WAIT_LOCK;
                    rst_out_n <= 1'b0;
                    ready     <= 1'b0;
                    hcnt      <= '0;
                    heartbeat <= 1'b0;
                    qcnt      <= '0;
                end
            endcase
        end
endmodule

// File: tb/tb_pll_lock_rst_gen.sv
// tb_pll_lock_rst_gen: directed checks of lock qualification, loss counting and heartbeat.
module tb_pll_lock_rst_gen;
    logic       clk_div = 1'b0;
    logic       sys_rst_n = 1'b1;
    logic       locked = 1'b0;
    logic       rst_out_n, ready, heartbeat;
    logic [1:0] loss_cnt;
    logic [1:0] state;
    int errors = 0;
    int checks = 0;

    pll_lock_rst_gen #(.STABLE_CYCLES(4), .LOSS_CNT_W(2), .HB_DIV(5)) dut (
        .clk_div(clk_div), .sys_rst_n(sys_rst_n), .locked(locked),
        .rst_out_n(rst_out_n), .ready(ready), .loss_cnt(loss_cnt),
        .heartbeat(heartbeat), .state(state)
    );

    always #5 clk_div = ~clk_div;

    task automatic step(input int n);
        repeat (n) @(posedge clk_div);
        #1;
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        locked = 1'b0;
        step(2);
        sys_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        locked = 1'b1;
        step(3);
        checks++;
        if ({state, rst_out_n, ready, heartbeat, loss_cnt} !== 7'b0) begin
            errors++;
            $display("FAIL reset_hold: got st=%b rst=%b rdy=%b hb=%b loss=%0d, want all 0",
                     state, rst_out_n, ready, heartbeat, loss_cnt);
        end
        locked = 1'b0;
        sys_rst_n = 1'b1;
        step(3);
        checks++;
        if (state !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle: state got %b want 00", state);
        end
    endtask

    task automatic test_lock_clean();
        do_reset();
        locked = 1'b1;
        step(2);
        checks++;
        if (state !== 2'b00) begin
            errors++;
            $display("FAIL clean_e1: state got %b want 00", state);
        end
        step(1);
        checks++;
        if (state !== 2'b01) begin
            errors++;
            $display("FAIL clean_e2: state got %b want 01", state);
        end
        step(3);
        checks++;
        if ({rst_out_n, ready} !== 2'b00) begin
            errors++;
            $display("FAIL clean_e5: rst/ready got %b%b want 00", rst_out_n, ready);
        end
        step(1);
        checks++;
        if ({state, rst_out_n, ready, loss_cnt} !== 6'b10_1_1_00) begin
            errors++;
            $display("FAIL clean_e6: st=%b rst=%b rdy=%b loss=%0d want st=10 rst=1 rdy=1 loss=0",
                     state, rst_out_n, ready, loss_cnt);
        end
    endtask

    task automatic test_qualify_abort();
        logic seen;
        do_reset();
        locked = 1'b1;
        step(3);
        locked = 1'b0;
        step(1);
        locked = 1'b1;
        step(1);
        checks++;
        if (state !== 2'b01) begin
            errors++;
            $display("FAIL abort_e4: state got %b want 01", state);
        end
        step(1);
        checks++;
        if ({state, loss_cnt} !== 4'b00_00) begin
            errors++;
            $display("FAIL abort_e5: st=%b loss=%0d want st=00 loss=0", state, loss_cnt);
        end
        seen = rst_out_n;
        for (int i = 0; i < 4; i++) begin
            step(1);
            seen |= rst_out_n;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL abort_window: rst_out_n got %b before fresh window, want 0", seen);
        end
        step(1);
        checks++;
        if ({state, rst_out_n} !== 3'b10_1) begin
            errors++;
            $display("FAIL abort_release: st=%b rst=%b want st=10 rst=1", state, rst_out_n);
        end
    endtask

    task automatic test_heartbeat();
        int toggles = 0;
        int bad = 0;
        logic prev = heartbeat;
        checks++;
        if (heartbeat !== 1'b0) begin
            errors++;
            $display("FAIL hb_entry: heartbeat got %b want 0", heartbeat);
        end
        for (int k = 1; k <= 30; k++) begin
            step(1);
            if (heartbeat !== 1'((k / 5) % 2)) bad++;
            if (k <= 15 && heartbeat !== prev) toggles++;
            prev = heartbeat;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hb_pattern: %0d cycles wrong, want 0", bad);
        end
        checks++;
        if (toggles != 3) begin
            errors++;
            $display("FAIL hb_toggles: got %0d toggles in 15 cycles want 3", toggles);
        end
    endtask

    task automatic test_loss_sat();
        do_reset();
        locked = 1'b1;
        step(7);
        for (int i = 1; i <= 5; i++) begin
            step(7);
            locked = 1'b0;
            step(2);
            checks++;
            if ({rst_out_n, heartbeat} !== 2'b11) begin
                errors++;
                $display("FAIL loss%0d_f1: rst=%b hb=%b want 1 1", i, rst_out_n, heartbeat);
            end
            step(1);
            checks++;
            if ({state, rst_out_n, ready, heartbeat, loss_cnt} !== {5'b00_0_0_0, 2'(i > 3 ? 3 : i)}) begin
                errors++;
                $display("FAIL loss%0d_f2: st=%b rst=%b rdy=%b hb=%b loss=%0d want st=00 rst=0 rdy=0 hb=0 loss=%0d",
                         i, state, rst_out_n, ready, heartbeat, loss_cnt, i > 3 ? 3 : i);
            end
            locked = 1'b1;
            step(7);
        end
    endtask

    task automatic test_async_reset();
        step(3);
        #2;
        sys_rst_n = 1'b0;
        #1;
        checks++;
        if ({state, rst_out_n, ready, heartbeat, loss_cnt} !== 7'b0) begin
            errors++;
            $display("FAIL async_rst: st=%b rst=%b rdy=%b hb=%b loss=%0d want all 0",
                     state, rst_out_n, ready, heartbeat, loss_cnt);
        end
        sys_rst_n = 1'b1;
        step(3);
        checks++;
        if (state !== 2'b01) begin
            errors++;
            $display("FAIL async_e2: state got %b want 01", state);
        end
        step(3);
        checks++;
        if (rst_out_n !== 1'b0) begin
            errors++;
            $display("FAIL async_e5: rst_out_n got %b want 0", rst_out_n);
        end
        step(1);
        checks++;
        if ({state, rst_out_n, loss_cnt} !== 5'b10_1_00) begin
            errors++;
            $display("FAIL async_e6: st=%b rst=%b loss=%0d want st=10 rst=1 loss=0", state, rst_out_n, loss_cnt);
        end
    endtask

    task automatic test_boundary_race();
        logic seen = 1'b0;
        do_reset();
        locked = 1'b1;
        step(4);
        locked = 1'b0;
        step(2);
        checks++;
        if (state !== 2'b01) begin
            errors++;
            $display("FAIL race_e5: state got %b want 01", state);
        end
        step(1);
        checks++;
        if ({state, rst_out_n, ready} !== 4'b00_0_0) begin
            errors++;
            $display("FAIL race_e6: st=%b rst=%b rdy=%b want st=00 rst=0 rdy=0", state, rst_out_n, ready);
        end
        for (int i = 0; i < 4; i++) begin
            step(1);
            seen |= rst_out_n;
        end
        checks++;
        if (seen !== 1'b0 || state !== 2'b00) begin
            errors++;
            $display("FAIL race_after: rst pulse=%b st=%b want 0 00", seen, state);
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_lock_clean();
        test_qualify_abort();
        test_heartbeat();
        test_loss_sat();
        test_async_reset();
        test_boundary_race();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
